// File: rtl/div_chk_pkg.sv
// Shared encodings and the architectural reference divide used by the result checker.
// div_expected works at MAX_XLEN; callers extend operands according to op signedness.
package div_chk_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;
  localparam int unsigned MAX_XLEN     = 64;

  localparam logic [1:0] DIV_OP_DIV  = 2'd0;
  localparam logic [1:0] DIV_OP_DIVU = 2'd1;
  localparam logic [1:0] DIV_OP_REM  = 2'd2;
  localparam logic [1:0] DIV_OP_REMU = 2'd3;

  // Narrower widths stay correct after extension: the signed overflow pair truncates back.
  function automatic logic [MAX_XLEN-1:0] div_expected(input logic [1:0]          op,
                                                       input logic [MAX_XLEN-1:0] a,
                                                       input logic [MAX_XLEN-1:0] b);
    logic signed [MAX_XLEN-1:0] sa;
    logic signed [MAX_XLEN-1:0] sb;
    logic                       ovf;
    logic [MAX_XLEN-1:0]        res;
    sa  = $signed(a);
    sb  = $signed(b);
    ovf = (a == {1'b1, {(MAX_XLEN-1){1'b0}}}) && (b == '1);
    res = '0;
    case (op)
      DIV_OP_DIV:  res = (b == '0) ? '1 : (ovf ? a : MAX_XLEN'(sa / sb));
      DIV_OP_DIVU: res = (b == '0) ? '1 : (a / b);
      DIV_OP_REM:  res = (b == '0) ? a : (ovf ? '0 : MAX_XLEN'(sa % sb));
      DIV_OP_REMU: res = (b == '0) ? a : (a % b);
      default:     res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/div_exp_fifo.sv
// In-order queue of expected divide results; a pop frees space for a push on the same edge.
module div_exp_fifo #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic                     pop_i,
  output logic [XLEN-1:0]          rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [XLEN-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == (PTR_W+1)'(DEPTH));
  assign w_do_pop  = pop_i && !empty_o;
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign rdata_o   = r_mem[r_rd_ptr];
  assign count_o   = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: contents are only observed through a non-zero count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/div_result_checker.sv
// Scoreboard for the divider: queues reference results per request and compares on response.
// Error flags are sticky until reset; head expectation is exported for formal properties.
module div_result_checker
  import div_chk_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEFAULT,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  input  logic [1:0]               req_op_i,
  input  logic [XLEN-1:0]          req_a_i,
  input  logic [XLEN-1:0]          req_b_i,
  input  logic                     rsp_valid_i,
  input  logic [XLEN-1:0]          rsp_result_i,
  output logic                     exp_valid_o,
  output logic [XLEN-1:0]          exp_result_o,
  output logic [$clog2(DEPTH):0]   outstanding_o,
  output logic [31:0]              chk_count_o,
  output logic                     err_mismatch_o,
  output logic                     err_underflow_o,
  output logic                     err_overflow_o,
  output logic                     err_timeout_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic                w_signed_op;
  logic [MAX_XLEN-1:0] w_a_ext;
  logic [MAX_XLEN-1:0] w_b_ext;
  logic [MAX_XLEN-1:0] w_exp_full;
  logic [XLEN-1:0]     w_head;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic [TMO_W-1:0]    w_tmo_d;

  logic [TMO_W-1:0]    r_tmo_cnt;
  logic [31:0]         r_chk_count;
  logic                r_err_mismatch;
  logic                r_err_underflow;
  logic                r_err_overflow;
  logic                r_err_timeout;

  assign w_signed_op = (req_op_i == DIV_OP_DIV) || (req_op_i == DIV_OP_REM);
  assign w_a_ext     = w_signed_op ? MAX_XLEN'($signed(req_a_i)) : MAX_XLEN'(req_a_i);
  assign w_b_ext     = w_signed_op ? MAX_XLEN'($signed(req_b_i)) : MAX_XLEN'(req_b_i);
  assign w_exp_full  = div_expected(req_op_i, w_a_ext, w_b_ext);
  assign w_pop       = rsp_valid_i && !w_empty;

  div_exp_fifo #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid_i),
    .wdata_i (w_exp_full[XLEN-1:0]),
    .pop_i   (rsp_valid_i),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (outstanding_o)
  );

  always_comb begin
    w_tmo_d = r_tmo_cnt;
    if (w_pop || w_empty) begin
      w_tmo_d = '0;
    end else if (r_tmo_cnt != TMO_W'(TIMEOUT)) begin
      w_tmo_d = r_tmo_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt       <= '0;
      r_chk_count     <= '0;
      r_err_mismatch  <= 1'b0;
      r_err_underflow <= 1'b0;
      r_err_overflow  <= 1'b0;
      r_err_timeout   <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_d;
      if (w_pop) r_chk_count <= r_chk_count + 32'd1;
      if (w_pop && (rsp_result_i != w_head))         r_err_mismatch  <= 1'b1;
      if (rsp_valid_i && w_empty)                    r_err_underflow <= 1'b1;
      if (req_valid_i && w_full && !w_pop)           r_err_overflow  <= 1'b1;
      if (!w_empty && (w_tmo_d == TMO_W'(TIMEOUT)))  r_err_timeout   <= 1'b1;
    end
  end

  assign exp_valid_o     = !w_empty;
  assign exp_result_o    = w_empty ? '0 : w_head;
  assign chk_count_o     = r_chk_count;
  assign err_mismatch_o  = r_err_mismatch;
  assign err_underflow_o = r_err_underflow;
  assign err_overflow_o  = r_err_overflow;
  assign err_timeout_o   = r_err_timeout;

endmodule

// File: tb/tb_div_result_checker.sv
// Bench for div_result_checker: an independent sign/magnitude divide model feeds a
// scoreboard queue whose head is compared with exp_result_o whenever a response is sent.
module tb_div_result_checker;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 64;

  logic            clk;
  logic            rst;
  logic            req_valid_i;
  logic [1:0]      req_op_i;
  logic [XLEN-1:0] req_a_i;
  logic [XLEN-1:0] req_b_i;
  logic            rsp_valid_i;
  logic [XLEN-1:0] rsp_result_i;
  logic            exp_valid_o;
  logic [XLEN-1:0] exp_result_o;
  logic [3:0]      outstanding_o;
  logic [31:0]     chk_count_o;
  logic            err_mismatch_o;
  logic            err_underflow_o;
  logic            err_overflow_o;
  logic            err_timeout_o;

  logic [63:0] q_exp [$];
  int          n_checks;
  int          n_errors;
  int          n_pops;

  div_result_checker #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid_i),
    .req_op_i        (req_op_i),
    .req_a_i         (req_a_i),
    .req_b_i         (req_b_i),
    .rsp_valid_i     (rsp_valid_i),
    .rsp_result_i    (rsp_result_i),
    .exp_valid_o     (exp_valid_o),
    .exp_result_o    (exp_result_o),
    .outstanding_o   (outstanding_o),
    .chk_count_o     (chk_count_o),
    .err_mismatch_o  (err_mismatch_o),
    .err_underflow_o (err_underflow_o),
    .err_overflow_o  (err_overflow_o),
    .err_timeout_o   (err_timeout_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sign/magnitude formulation; the overflow pair falls out without a special case.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    logic [63:0] ua, ub, q, r;
    logic        is_div, is_signed;
    is_div    = (op == 2'd0) || (op == 2'd1);
    is_signed = (op == 2'd0) || (op == 2'd2);
    if (b == 64'd0) return is_div ? 64'hFFFF_FFFF_FFFF_FFFF : a;
    ua = (is_signed && a[63]) ? (~a + 64'd1) : a;
    ub = (is_signed && b[63]) ? (~b + 64'd1) : b;
    q  = ua / ub;
    r  = ua % ub;
    if (is_signed && (a[63] ^ b[63])) q = ~q + 64'd1;
    if (is_signed && a[63])           r = ~r + 64'd1;
    return is_div ? q : r;
  endfunction

  // One clock of stimulus; a response compares the DUT head with the scoreboard head.
  task automatic drive(input logic do_req, input logic [1:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic do_rsp, input logic use_val,
                       input logic [63:0] val);
    logic [63:0] head;
    logic        popping;
    popping      = do_rsp && (q_exp.size() > 0);
    req_valid_i  = do_req;
    req_op_i     = op;
    req_a_i      = a;
    req_b_i      = b;
    rsp_valid_i  = do_rsp;
    rsp_result_i = use_val ? val : 64'd0;
    if (popping) begin
      head = q_exp.pop_front();
      check_eq("head", exp_result_o, head);
      if (!use_val) rsp_result_i = head;
      n_pops++;
    end
    if (do_req && (q_exp.size() < DEPTH)) q_exp.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    rsp_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b0, 64'd0);
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp);
    check_eq(tag, {60'd0, err_mismatch_o, err_underflow_o, err_overflow_o, err_timeout_o},
             {60'd0, exp});
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {exp_valid_o, exp_result_o, outstanding_o, chk_count_o, err_mismatch_o,
                   err_underflow_o, err_overflow_o, err_timeout_o} == '0 ? 64'd0 : 64'd1,
             64'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    q_exp.delete();
    n_pops = 0;
    @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    rst = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    n_pops       = 0;
    rst          = 1'b1;
    req_valid_i  = 1'b0;
    req_op_i     = 2'd0;
    req_a_i      = '0;
    req_b_i      = '0;
    rsp_valid_i  = 1'b0;
    rsp_result_i = '0;
    #3;
    check_all_zero("por_outputs");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // DIVU 100/7, answered two cycles later.
    drive(1'b1, 2'd1, 64'd100, 64'd7, 1'b0, 1'b0, 64'd0);
    check_eq("divu_valid", {63'd0, exp_valid_o}, 64'd1);
    check_eq("divu_exp", exp_result_o, 64'd14);
    idle(1);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd14);
    check_eq("divu_count", {32'd0, chk_count_o}, 64'd1);
    check_eq("divu_outst", {60'd0, outstanding_o}, 64'd0);
    check_errs("divu_errs", 4'b0000);

    // Signed overflow pair.
    drive(1'b1, 2'd0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 2'd2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 64'd0);
    check_eq("ovf_div_exp", exp_result_o, 64'h8000_0000_0000_0000);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'h8000_0000_0000_0000);
    check_eq("ovf_rem_exp", exp_result_o, 64'd0);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0);
    check_eq("ovf_count", {32'd0, chk_count_o}, 64'd3);

    // Divide by zero.
    drive(1'b1, 2'd1, 64'd5, 64'd0, 1'b0, 1'b0, 64'd0);
    drive(1'b1, 2'd3, 64'd5, 64'd0, 1'b0, 1'b0, 64'd0);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd5);
    check_errs("dz_errs", 4'b0000);

    // Fill, overflow, push+pop while full, then drain.
    for (int i = 0; i < DEPTH; i++)
      drive(1'b1, 2'(i), {$urandom, $urandom}, 64'({$urandom} >> i) | 64'd1,
            1'b0, 1'b0, 64'd0);
    check_eq("full_outst", {60'd0, outstanding_o}, 64'd8);
    drive(1'b1, 2'd1, 64'd77, 64'd3, 1'b0, 1'b0, 64'd0);
    check_eq("ovf_flag", {63'd0, err_overflow_o}, 64'd1);
    check_eq("ovf_outst", {60'd0, outstanding_o}, 64'd8);
    drive(1'b1, 2'd0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd9, 1'b1, 1'b0, 64'd0);
    check_eq("pp_outst", {60'd0, outstanding_o}, 64'd8);
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    check_eq("drain_count", {32'd0, chk_count_o}, 64'(n_pops));
    check_eq("drain_outst", {60'd0, outstanding_o}, 64'd0);
    check_errs("drain_errs", 4'b0010);

    // Underflow, including empty queue with a same-cycle push.
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd0);
    check_eq("udf_flag", {63'd0, err_underflow_o}, 64'd1);
    check_eq("udf_count", {32'd0, chk_count_o}, 64'(n_pops));
    drive(1'b1, 2'd1, 64'd21, 64'd4, 1'b1, 1'b1, 64'd5);
    check_eq("udf_push_outst", {60'd0, outstanding_o}, 64'd1);
    check_eq("udf_push_count", {32'd0, chk_count_o}, 64'(n_pops));
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    check_errs("udf_errs", 4'b0110);

    // REM -7/2 answered with 1.
    drive(1'b1, 2'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, 64'd0);
    check_eq("rem_neg_exp", exp_result_o, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b1, 64'd1);
    check_eq("mm_flag", {63'd0, err_mismatch_o}, 64'd1);

    // Timeout after exactly TIMEOUT cycles without a response.
    apply_reset();
    drive(1'b1, 2'd1, 64'd1, 64'd1, 1'b0, 1'b0, 64'd0);
    idle(TIMEOUT - 1);
    check_eq("tmo_early", {63'd0, err_timeout_o}, 64'd0);
    idle(1);
    check_eq("tmo_flag", {63'd0, err_timeout_o}, 64'd1);

    // Asynchronous reset between clock edges.
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset");
    q_exp.delete();
    n_pops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 2'd1, 64'd9, 64'd3, 1'b0, 1'b0, 64'd0);
    check_eq("post_rst_exp", exp_result_o, 64'd3);
    drive(1'b0, 2'd0, 64'd0, 64'd0, 1'b1, 1'b0, 64'd0);
    check_eq("post_rst_count", {32'd0, chk_count_o}, 64'd1);
    check_errs("post_rst_errs", 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
